// File: rtl/fan_ctrl_pkg.sv
// Shared level type and duty-fraction helpers for the fan speed controller.
package fan_ctrl_pkg;

  typedef enum logic [1:0] {
    LVL_OFF  = 2'd0,
    LVL_LOW  = 2'd1,
    LVL_MED  = 2'd2,
    LVL_HIGH = 2'd3
  } fan_level_t;

  localparam int unsigned DUTY_LOW_NUM = 32'd2;
  localparam int unsigned DUTY_LOW_DEN = 32'd5;
  localparam int unsigned DUTY_MED_NUM = 32'd7;
  localparam int unsigned DUTY_MED_DEN = 32'd10;

  // Intended for elaboration-time use only; the divisions must not reach hardware.
  function automatic logic [11:0] level_to_duty(input fan_level_t level, input logic [11:0] period);
    logic [31:0] w_p;
    logic [31:0] w_res;
    w_p = {20'd0, period};
    case (level)
      LVL_OFF:  w_res = 32'd0;
      LVL_LOW:  w_res = (w_p * DUTY_LOW_NUM) / DUTY_LOW_DEN;
      LVL_MED:  w_res = (w_p * DUTY_MED_NUM) / DUTY_MED_DEN;
      LVL_HIGH: w_res = w_p;
      default:  w_res = 32'd0;
    endcase
    return w_res[11:0];
  endfunction

endpackage

// File: rtl/fan_speed_controller_pwm.sv
// Glitch-free PWM: duty is only adopted at the period boundary, output is registered.
module fan_pwm_generator #(
  parameter logic [11:0] PWM_PERIOD = 12'd4000
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  input  logic [11:0] duty,
  output logic        pwm
);

  logic [11:0] r_pcnt;
  logic [11:0] r_duty_act;
  logic        r_pwm;
  logic        w_wrap;

  assign w_wrap = (r_pcnt == (PWM_PERIOD - 12'd1));

  // Period counter, boundary duty latch and registered compare.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_pcnt     <= 12'd0;
      r_duty_act <= 12'd0;
      r_pwm      <= 1'b0;
    end else begin
      r_pcnt <= w_wrap ? 12'd0 : (r_pcnt + 12'd1);
      if (w_wrap) begin
        r_duty_act <= duty;
      end
      r_pwm <= (r_pcnt < r_duty_act);
    end
  end

  assign pwm = r_pwm;

endmodule

// File: rtl/fan_speed_controller.sv
// Temperature-driven fan controller: input capture, sample tick, hysteretic
// level FSM and duty ramp feeding the PWM generator.
module fan_speed_controller
  import fan_ctrl_pkg::*;
#(
  parameter logic [11:0] PWM_PERIOD   = 12'd4000,
  parameter logic [23:0] SAMPLE_TICKS = 24'd10_000_000,
  parameter logic [7:0]  T_LOW        = 8'd25,
  parameter logic [7:0]  T_MED        = 8'd30,
  parameter logic [7:0]  T_HIGH       = 8'd35,
  parameter logic [7:0]  HYST         = 8'd2,
  parameter logic [11:0] RAMP_STEP    = 12'd200
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  input  logic [7:0]  temperature_c,
  output logic        pwm,
  output logic [1:0]  fan_level,
  output logic [11:0] duty,
  output logic        fan_on
);

  localparam logic [1:0] ST_OFF  = LVL_OFF;
  localparam logic [1:0] ST_LOW  = LVL_LOW;
  localparam logic [1:0] ST_MED  = LVL_MED;
  localparam logic [1:0] ST_HIGH = LVL_HIGH;

  localparam logic [11:0] DUTY_LOW = level_to_duty(LVL_LOW, PWM_PERIOD);
  localparam logic [11:0] DUTY_MED = level_to_duty(LVL_MED, PWM_PERIOD);

  // A saturated threshold of 0 can never be undercut, which disables that down step.
  localparam logic [7:0] T_LOW_DN  = (HYST > T_LOW)  ? 8'd0 : (T_LOW  - HYST);
  localparam logic [7:0] T_MED_DN  = (HYST > T_MED)  ? 8'd0 : (T_MED  - HYST);
  localparam logic [7:0] T_HIGH_DN = (HYST > T_HIGH) ? 8'd0 : (T_HIGH - HYST);

  logic [7:0]  r_sync1;
  logic [7:0]  r_sync2;
  logic [7:0]  r_temp_stable;
  logic [23:0] r_tick_cnt;
  logic        w_tick;
  logic [1:0]  r_level;
  logic [1:0]  w_level_nxt;
  logic [11:0] r_duty;
  logic [11:0] w_target;
  logic [11:0] w_delta;
  logic [11:0] w_duty_ramp;
  logic        r_fan_on;

  assign w_tick = (r_tick_cnt == (SAMPLE_TICKS - 24'd1));

  // Synchronizer plus two-cycle agreement filter on the captured temperature.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_sync1       <= 8'd0;
      r_sync2       <= 8'd0;
      r_temp_stable <= 8'd0;
    end else begin
      r_sync1 <= temperature_c;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_sync1) begin
        r_temp_stable <= r_sync2;
      end
    end
  end

  // Sample tick counter.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= 24'd0;
    end else begin
      r_tick_cnt <= w_tick ? 24'd0 : (r_tick_cnt + 24'd1);
    end
  end

  // Next level: one step at most, upward on threshold, downward below threshold minus hysteresis.
  always_comb begin
    w_level_nxt = r_level;
    case (r_level)
      ST_OFF: begin
        if (r_temp_stable >= T_LOW) w_level_nxt = ST_LOW;
        else                        w_level_nxt = ST_OFF;
      end
      ST_LOW: begin
        if (r_temp_stable >= T_MED)         w_level_nxt = ST_MED;
        else if (r_temp_stable < T_LOW_DN)  w_level_nxt = ST_OFF;
        else                                w_level_nxt = ST_LOW;
      end
      ST_MED: begin
        if (r_temp_stable >= T_HIGH)        w_level_nxt = ST_HIGH;
        else if (r_temp_stable < T_MED_DN)  w_level_nxt = ST_LOW;
        else                                w_level_nxt = ST_MED;
      end
      ST_HIGH: begin
        if (r_temp_stable < T_HIGH_DN) w_level_nxt = ST_MED;
        else                           w_level_nxt = ST_HIGH;
      end
      default: w_level_nxt = ST_OFF;
    endcase
  end

  // Ramp toward the new level's target, clamped so it never overshoots.
  always_comb begin
    w_target    = 12'd0;
    w_delta     = 12'd0;
    w_duty_ramp = r_duty;
    case (w_level_nxt)
      ST_OFF:  w_target = 12'd0;
      ST_LOW:  w_target = DUTY_LOW;
      ST_MED:  w_target = DUTY_MED;
      ST_HIGH: w_target = PWM_PERIOD;
      default: w_target = 12'd0;
    endcase
    if (w_target >= r_duty) begin
      w_delta = w_target - r_duty;
      if (w_delta > RAMP_STEP) w_duty_ramp = r_duty + RAMP_STEP;
      else                     w_duty_ramp = w_target;
    end else begin
      w_delta = r_duty - w_target;
      if (w_delta > RAMP_STEP) w_duty_ramp = r_duty - RAMP_STEP;
      else                     w_duty_ramp = w_target;
    end
  end

  // Level, duty and fan_on commit together on the sample tick.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_level  <= ST_OFF;
      r_duty   <= 12'd0;
      r_fan_on <= 1'b0;
    end else if (w_tick) begin
      r_level  <= w_level_nxt;
      r_duty   <= w_duty_ramp;
      r_fan_on <= (w_duty_ramp != 12'd0);
    end
  end

  fan_pwm_generator #(
    .PWM_PERIOD(PWM_PERIOD)
  ) u_pwm (
    .clk_100MHz(clk_100MHz),
    .rst       (rst),
    .duty      (r_duty),
    .pwm       (pwm)
  );

  assign fan_level = r_level;
  assign duty      = r_duty;
  assign fan_on    = r_fan_on;

endmodule

// File: tb/tb_fan_speed_controller.sv
// Scoreboard bench for fan_speed_controller with a cycle-indexed reference model.
`timescale 1ns/1ps
module tb_fan_speed_controller;

  localparam int PER   = 20;
  localparam int TICKS = 10;
  localparam int STEP  = 4;
  localparam int HYS   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  temp = 8'd40;
  logic        pwm;
  logic [1:0]  fan_level;
  logic [11:0] duty;
  logic        fan_on;

  int checks   = 0;
  int failures = 0;

  fan_speed_controller #(
    .PWM_PERIOD  (12'd20),
    .SAMPLE_TICKS(24'd10),
    .RAMP_STEP   (12'd4)
  ) dut (
    .clk_100MHz   (clk),
    .rst          (rst),
    .temperature_c(temp),
    .pwm          (pwm),
    .fan_level    (fan_level),
    .duty         (duty),
    .fan_on       (fan_on)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pwm;
    logic [1:0]  lvl;
    logic [11:0] duty;
    logic        on;
  } exp_t;

  exp_t sb_q[$];

  // Model state: m_e counts rising edges since reset release.
  int m_e, m_lvl, m_duty, m_dact, m_stable, m_t1, m_t2, m_pwm, m_tgt;
  exp_t m_x;
  exp_t mon_x;

  function automatic int up_th(input int lvl);
    case (lvl)
      0:       return 25;
      1:       return 30;
      default: return 35;
    endcase
  endfunction

  function automatic int next_level(input int lvl, input int t);
    int dn;
    if (lvl < 3 && t >= up_th(lvl)) return lvl + 1;
    if (lvl > 0) begin
      dn = up_th(lvl - 1) - HYS;
      if (dn < 0) dn = 0;
      if (t < dn) return lvl - 1;
    end
    return lvl;
  endfunction

  function automatic int target_of(input int lvl);
    case (lvl)
      0:       return 0;
      1:       return PER * 2 / 5;
      2:       return PER * 7 / 10;
      default: return PER;
    endcase
  endfunction

  // Reference model: expected outputs after each rising edge go into the scoreboard.
  always @(posedge clk) begin
    if (rst) begin
      m_e = 0; m_lvl = 0; m_duty = 0; m_dact = 0; m_stable = 0;
      m_t1 = 0; m_t2 = 0; m_pwm = 0;
    end else begin
      m_e = m_e + 1;
      m_pwm = (((m_e - 1) % PER) < m_dact) ? 1 : 0;
      if (m_e % PER == 0) m_dact = m_duty;
      if (m_e % TICKS == 0) begin
        m_lvl = next_level(m_lvl, m_stable);
        m_tgt = target_of(m_lvl);
        if (m_tgt > m_duty)      m_duty = m_duty + ((m_tgt - m_duty > STEP) ? STEP : (m_tgt - m_duty));
        else if (m_tgt < m_duty) m_duty = m_duty - ((m_duty - m_tgt > STEP) ? STEP : (m_duty - m_tgt));
      end
      if (m_t2 == m_t1) m_stable = m_t2;
      m_t2 = m_t1;
      m_t1 = int'(temp);
    end
    m_x.pwm  = m_pwm[0];
    m_x.lvl  = m_lvl[1:0];
    m_x.duty = m_duty[11:0];
    m_x.on   = (m_duty != 0);
    sb_q.push_back(m_x);
  end

  // Monitor: one scoreboard entry per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_x = sb_q.pop_front();
      checks = checks + 1;
      if ({pwm, fan_level, duty, fan_on} !== mon_x) begin
        failures = failures + 1;
        $display("FAIL outputs t=%0t got pwm=%0b lvl=%0d duty=%0d on=%0b want pwm=%0b lvl=%0d duty=%0d on=%0b",
                 $time, pwm, fan_level, duty, fan_on, mon_x.pwm, mon_x.lvl, mon_x.duty, mon_x.on);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks = checks + 1;
    if (got != want) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic count_high(output int n);
    n = 0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      if (pwm) n = n + 1;
    end
  endtask

  int hi_a, hi_b;

  initial begin
    rst  = 1'b1;
    temp = 8'd40;
    repeat (4) @(negedge clk);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_level", int'(fan_level), 0);
    chk("rst_duty", int'(duty), 0);
    chk("rst_fan_on", int'(fan_on), 0);
    #1 rst = 1'b0;

    repeat (60) @(negedge clk);
    chk("ramp_level", int'(fan_level), 3);
    chk("ramp_duty", int'(duty), 20);
    chk("ramp_fan_on", int'(fan_on), 1);
    count_high(hi_a);
    chk("full_duty_high", hi_a, 20);

    temp = 8'd34;
    repeat (40) @(negedge clk);
    chk("hyst_hold_high", int'(fan_level), 3);
    temp = 8'd32;
    repeat (50) @(negedge clk);
    chk("hyst_med_level", int'(fan_level), 2);
    chk("hyst_med_duty", int'(duty), 14);

    temp = 8'd27;
    repeat (50) @(negedge clk);
    chk("low_level", int'(fan_level), 1);
    chk("low_duty", int'(duty), 8);
    for (int i = 0; i < 10; i++) begin
      temp = (i % 2 == 0) ? 8'd24 : 8'd23;
      repeat ($urandom_range(3, 15)) @(negedge clk);
    end
    chk("band_hold_low", int'(fan_level), 1);

    temp = 8'd22;
    repeat (50) @(negedge clk);
    chk("off_level", int'(fan_level), 0);
    chk("off_duty", int'(duty), 0);
    chk("off_fan_on", int'(fan_on), 0);

    // Align the LOW->MED step to mid-period so the change lands inside a running period.
    temp = 8'd26;
    repeat (50) @(negedge clk);
    for (int i = 0; i < 40 && (m_e % PER) != 0; i++) @(negedge clk);
    temp = 8'd31;
    count_high(hi_a);
    count_high(hi_b);
    chk("glitch_cur_period", hi_a, 8);
    chk("glitch_next_period", hi_b, 12);

    #1 rst = 1'b1;
    temp = 8'd40;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 100 && m_e != 25; i++) @(negedge clk);
    chk("pre_reset_duty", int'(duty), 8);
    #1 rst = 1'b1;
    #1;
    chk("midrst_pwm", int'(pwm), 0);
    chk("midrst_level", int'(fan_level), 0);
    chk("midrst_duty", int'(duty), 0);
    chk("midrst_fan_on", int'(fan_on), 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("rerun_level", int'(fan_level), 3);
    chk("rerun_duty", int'(duty), 20);

    for (int i = 0; i < 30; i++) begin
      temp = 8'($urandom_range(15, 45));
      repeat ($urandom_range(1, 25)) @(negedge clk);
    end
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fan_speed_controller.md
# fan_speed_controller

Consumes the 8-bit Celsius temperature produced by the ADT7420 driver stage and drives the smart-fan PWM output. The block samples the temperature periodically and selects one of four fan levels with hysteresis. It ramps the PWM duty toward that level's target and generates a glitch-free PWM waveform. It sits directly downstream of the temperature driver in the top-level design.

## Interface
- `PWM_PERIOD`, default 12'd4000, PWM period in clk cycles (25 kHz at 100 MHz); legal 2..4095
- `SAMPLE_TICKS`, default 24'd10_000_000, cycles between temperature evaluations (100 ms)
- `T_LOW`, default 8'd25, °C threshold to enter LOW
- `T_MED`, default 8'd30, °C threshold to enter MED
- `T_HIGH`, default 8'd35, °C threshold to enter HIGH
- `HYST`, default 8'd2, °C hysteresis applied on downward transitions
- `RAMP_STEP`, default 12'd200, max duty change per sample tick
- `clk_100MHz` in 1: system clock; one clock, all logic on the rising edge
- `rst` in 1: asynchronous, active-high reset
- `temperature_c` in 8: unsigned °C from the driver stage; its source domain is asynchronous to this block
- `pwm` out 1: fan PWM drive, active high
- `fan_level` out 2: current level (0 OFF, 1 LOW, 2 MED, 3 HIGH)
- `duty` out 12: current ramped duty in clk cycles of high time
- `fan_on` out 1: high when `duty != 0`

## Operation
- Input capture:
  - `temperature_c` passes through a 2-flop synchronizer.
  - `temp_stable` updates only when the synchronized value is equal on two consecutive cycles.
- Sample tick:
  - A counter runs 0..SAMPLE_TICKS-1 and pulses `tick` for one cycle at wrap.
- Level FSM, states OFF/LOW/MED/HIGH, evaluated on `tick` only, at most one level step per tick:
  - OFF→LOW if temp ≥ T_LOW
  - LOW→MED if temp ≥ T_MED
  - MED→HIGH if temp ≥ T_HIGH
  - HIGH→MED if temp < T_HIGH−HYST
  - MED→LOW if temp < T_MED−HYST
  - LOW→OFF if temp < T_LOW−HYST
  - otherwise hold
  - Down-threshold subtraction saturates at 0: if HYST > threshold, that down transition never occurs.
- Target duty per level:
  - OFF 0
  - LOW PWM_PERIOD*2/5
  - MED PWM_PERIOD*7/10
  - HIGH PWM_PERIOD
  - Integer division; computed at elaboration.
- Ramp, on `tick`, after the FSM update of the same tick:
  - `duty` moves toward the new target by min(RAMP_STEP, |target−duty|).
  - It never overshoots. It holds when equal.
- PWM:
  - Counter `pcnt` runs 0..PWM_PERIOD-1.
  - `pwm` = registered (`pcnt < duty_act`).
  - `duty_act` latches `duty` only when `pcnt == PWM_PERIOD-1`, so a period never contains a partial duty change.
  - duty_act = 0 gives `pwm` constantly 0; duty_act = PWM_PERIOD gives `pwm` constantly 1.
- Reset, including mid-operation: all counters, FSM (OFF), `duty`, `duty_act`, synchronizer and `temp_stable` clear immediately.
- Reset values of every output:
  - `pwm` 0
  - `fan_level` 0
  - `duty` 0
  - `fan_on` 0
- `temp_stable` resets to 0, so after reset the fan stays OFF until a valid sample above T_LOW.

## Timing
- Input to `temp_stable`: 3 cycles for a clean step (2 synchronizer cycles plus 1 stability cycle).
- `fan_level` and `duty` update on the cycle after `tick`. FSM and ramp are combinational from the same `tick`, registered together.
- `fan_on` is registered alongside `duty`.
- `duty` to `pwm`: takes effect at the next PWM period boundary.
  - `duty_act` loads on the cycle after `pcnt == PWM_PERIOD-1`.
  - `pwm` reflects it one cycle later (registered output).
- A temperature change coincident with `tick` is seen on the following tick.

## Structure
- Package `fan_ctrl_pkg`:
  - `fan_level_t` enum (2-bit, OFF=0..HIGH=3)
  - duty fraction constants (2/5, 7/10)
  - function `level_to_duty(level, period)`
- Sub-module `fan_pwm_generator`:
  - ports: `clk_100MHz`, `rst`, `duty`
  - contains `pcnt`, `duty_act` latch and the `pwm` register
  - parameter: PWM_PERIOD
- Top of block: synchronizer, stability filter, tick counter, level FSM and ramp.

## Test plan
Bench parameters: PWM_PERIOD=20, SAMPLE_TICKS=10, RAMP_STEP=4; thresholds at defaults.
- Reset check: assert `rst` with temperature_c=40 → `pwm`, `fan_level`, `duty`, `fan_on` are all 0 while reset is held.
- Ramp up: release reset with temperature_c=40:
  - `fan_level` steps 1, 2, 3 on ticks 1, 2, 3 (tick 1 may be delayed by synchronizer latency)
  - `duty` steps 4, 8, 12, 16, 20
  - at steady state `pwm` is constantly 1
- Hysteresis: from HIGH, set temperature_c=34 → HIGH holds; set temperature_c=32 → MED after the next tick, and `duty` ramps down to 14.
- Band hold: in LOW, toggle temperature_c between 24 and 23 → stays LOW. Set temperature_c=22 → OFF, `duty` reaches 0, `fan_on` falls.
- Glitch-free update: change `duty` mid-period → the current period's `pwm` high time is unchanged and the next period's high time equals the new duty; check 8 → 12 high cycles.
- Reset mid-ramp: assert `rst` while `duty`=8 and `pcnt`=5 → all outputs are 0 within the same cycle; after release, the sequence repeats from OFF.
